// File: rtl/rr_arbiter_param.sv
// rr_arbiter_param: round-robin arbiter; in clk, rst_n, req[N], ready; out grant[N], grant_valid, grant_id; ARB_WEIGHT_EN holds a grant for up to WEIGHT handshakes
module rr_arbiter_param #(
  parameter int N = 4,
  parameter int WEIGHT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 ready,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id
);
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic grant_valid_q, grant_valid_d;
  logic [IW-1:0] grant_id_q, grant_id_d, ptr_q, ptr_d, win;
  logic [IW:0] idx;
  logic found, hs, last, release_g;
`ifdef ARB_WEIGHT_EN
  logic [3:0] credit_q, credit_d;
`endif
  if (N < 2 || N > 32 || WEIGHT < 1 || WEIGHT > 15) begin : g_bad_cfg
    $error("rr_arbiter_param: N or WEIGHT out of range");
  end
  always_comb begin
    hs = grant_valid_q && ready;
`ifdef ARB_WEIGHT_EN
    last = credit_q == 4'(WEIGHT - 1) || !req[grant_id_q];
    credit_d = hs ? credit_q + 4'd1 : credit_q;
`else
    last = 1'b1;
`endif
    release_g = state_q == BUSY && ((hs && last) || (!ready && !req[grant_id_q]));
    ptr_d = release_g ? (grant_id_q == IW'(N - 1) ? '0 : grant_id_q + IW'(1)) : ptr_q;
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr_d} + (IW+1)'(i);
      idx = idx >= (IW+1)'(N) ? idx - (IW+1)'(N) : idx;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        win = idx[IW-1:0];
      end
    end
    state_d = state_q;
    grant_d = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d = grant_id_q;
    if (state_q == IDLE || release_g) begin
      state_d = found ? BUSY : IDLE;
      grant_d = found ? N'(1) << win : '0;
      grant_valid_d = found;
      grant_id_d = found ? win : '0;
`ifdef ARB_WEIGHT_EN
      credit_d = '0;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q <= '0;
      ptr_q <= '0;
`ifdef ARB_WEIGHT_EN
      credit_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q <= grant_id_d;
      ptr_q <= ptr_d;
`ifdef ARB_WEIGHT_EN
      credit_q <= credit_d;
`endif
    end
  end
  assign grant = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id = grant_id_q;
endmodule
